corr_peak_picker: RTL and testbench
===================================

// Module: corr_peak_picker
// PURPOSE
//   Consumes the result pulses of the NCH-lane correlator bank, one lane per code
//   phase. Collects one result per lane per window, scans the snapshot for the
//   strongest lane, and hands {lane index, value} to the hex/UART dumper via valid/ack.
//   Sits between the correlator bank and hex_dump. Gives the coarse code-phase estimate.
// PARAMETERS
//   NCH      8       number of correlator lanes (>=2)
//   W        16      width of each correlator result, unsigned
//   TIMEOUT  65536   clk cycles from first lane result to forced scan of a partial window
// PORTS
//   clk         in   1        system clock (48 MHz osc)
//   rst         in   1        synchronous, active-high reset
//   corr_val    in   NCH*W    lane results; lane k = corr_val[k*W +: W]
//   corr_rdy    in   NCH      1-cycle pulse per lane: corr_val lane k valid this cycle
//   peak_valid  out  1        result held for dumper
//   peak_ack    in   1        dumper consumed result (sampled only while peak_valid=1)
//   peak_idx    out  log2(NCH) winning lane
//   peak_val    out  W        winning lane value
//   peak_partial out 1        window closed by timeout; not all lanes reported
//   peak_mask   out  NCH      lanes that reported in the scanned window
// BEHAVIOUR
//   - Reset: all outputs 0, state COLLECT, collect mask 0, timeout counter 0.
//   - Collection (always active, every state): corr_rdy[k]=1 -> lane k value into
//     collect reg k and set mask[k]. A second pulse on a lane in the same window
//     overwrites (latest wins). Several lanes may pulse in the same cycle.
//   - Timeout counter: clears while mask==0. Increments while mask!=0 and mask not full.
//     Saturates at TIMEOUT.
//   - Window ready = mask all-ones OR counter==TIMEOUT.
//   - FSM COLLECT: window ready and not holding a result -> copy collect regs + mask
//     into snapshot. Clear collect mask and counter in the same cycle.
//     A rdy pulse in that same cycle goes to the NEW window. Go to SCAN.
//   - SCAN: one lane per cycle, k=0..NCH-1 (NCH cycles). Compare only lanes with
//     snapshot mask[k]=1. Strict '>' compare, so ties resolve to the lowest index.
//     Best starts invalid; the first masked lane always loads.
//   - After lane NCH-1: load peak_* and set peak_valid on the next edge -> HOLD.
//     Latency: window-ready edge to peak_valid = NCH+1 cycles.
//   - HOLD: outputs stable until peak_ack=1 at a clock edge. peak_valid drops on that
//     edge -> COLLECT.
//     A window that becomes ready during SCAN/HOLD stays pending. Its values keep
//     updating (latest wins) and the counter stays saturated. It is snapshotted in the
//     first COLLECT cycle after the ack (no windows lost, none merged).
//   - peak_partial = snapshot mask != all-ones. A timeout with mask==0 cannot occur
//     (the counter only runs with mask!=0).
//   - peak_ack while peak_valid=0 is ignored.
//   - rst mid-SCAN/HOLD: immediate return to reset state; pending window discarded.
// CONFIGURATION
//   PEAK_MARGIN_EN defined: adds outputs peak_val2 [W] (second-best masked value,
//     ties counted) and peak_margin [W] = peak_val - peak_val2.
//     Both are 0 if only one lane reported. Both are tracked during the same SCAN
//     pass (no extra latency) and held with peak_valid.
//   PEAK_MARGIN_EN undefined: those ports and the runner-up register do not exist.
// TESTING
//   1 NCH=8: lanes 0..7 pulse once with values 10,20,90,30,40,50,60,70; hold ack=0.
//     -> peak_valid 9 cycles after lane-7 pulse; idx=2, val=90, partial=0, mask=FF.
//     Outputs stay stable until ack.
//   2 Tie: lanes 3 and 6 both = 500, others 100 -> idx=3, val=500.
//     With PEAK_MARGIN_EN: val2=500, margin=0.
//   3 Timeout: TIMEOUT=64; only lanes 1 (7) and 5 (9) pulse.
//     -> scan starts 64 cycles after lane-1 pulse; idx=5, val=9, partial=1, mask=22.
//   4 Backpressure: full window A (max lane 4); full window B (max lane 0) completes
//     while A unacked; B lane 0 rewritten to 300 before ack.
//     -> A then B reported in order; B val=300; valid deasserts 1 cycle after each ack.
//   5 Boundary: all 8 lanes pulse in the snapshot cycle of the previous window
//     -> counted in the next window, mask=FF, next result correct.
//   6 rst asserted mid-SCAN and mid-HOLD -> next edge: peak_valid=0, all outputs 0.
//     A fresh window then reports normally.

Source files
------------

// File: rtl/corr_peak_picker.sv
`default_nettype none
// ============================================================================
// Module   : corr_peak_picker
// Function : Gathers one result per correlator lane into a window. The window
//            closes when every lane has reported or a timeout expires. The
//            closed window is then scanned one lane per cycle, and the winning
//            {lane, value} is presented to the downstream dumper through a
//            valid/ack handshake.
// Options  : PEAK_MARGIN_EN - adds the runner-up value (peak_val2) and the
//            margin between winner and runner-up (peak_margin).
// Revision : 1.0 - initial release
// ============================================================================
module corr_peak_picker #(
  parameter int NCH     = 8,
  parameter int W       = 16,
  parameter int TIMEOUT = 65536,
  localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] corr_val,
  input  logic [NCH-1:0]   corr_rdy,
  output logic             peak_valid,
  input  logic             peak_ack,
  output logic [IW-1:0]    peak_idx,
  output logic [W-1:0]     peak_val,
  output logic             peak_partial,
  output logic [NCH-1:0]   peak_mask
`ifdef PEAK_MARGIN_EN
  ,
  output logic [W-1:0]     peak_val2,
  output logic [W-1:0]     peak_margin
`endif
);

  localparam logic [NCH-1:0] c_mask_full = {NCH{1'b1}};
  localparam logic [CW-1:0]  c_timeout   = CW'(TIMEOUT);
  localparam logic [IW-1:0]  c_last_lane = IW'(NCH - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SCAN    = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Window being collected
  logic [W-1:0]   coll_val_q [NCH];
  logic [NCH-1:0] coll_mask_q, coll_mask_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Frozen copy of the closed window
  logic [W-1:0]   snap_val_q [NCH];
  logic [NCH-1:0] snap_mask_q;

  // Running best during the scan
  logic [IW-1:0]  scan_k_q;
  logic           best_valid_q, best_valid_d;
  logic [IW-1:0]  best_idx_q, best_idx_d;
  logic [W-1:0]   best_val_q, best_val_d;
`ifdef PEAK_MARGIN_EN
  logic           sec_valid_q, sec_valid_d;
  logic [W-1:0]   sec_val_q, sec_val_d;
  logic [W-1:0]   w_val2, w_margin;
  logic [W-1:0]   peak_val2_q, peak_margin_q;
`endif

  // Output holding registers
  logic           peak_valid_q;
  logic [IW-1:0]  peak_idx_q;
  logic [W-1:0]   peak_val_q;
  logic           peak_partial_q;
  logic [NCH-1:0] peak_mask_q;

  // FSM strobes
  logic           w_win_ready;
  logic           w_take;
  logic           w_scan;
  logic           w_last;
  logic           w_drop;
  logic [W-1:0]   w_lane_val;
  logic           w_lane_en;

  assign w_win_ready = (coll_mask_q == c_mask_full) || (cnt_q == c_timeout);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and one-cycle control strobes
  always_comb begin
    state_d = state_q;
    w_take  = 1'b0;
    w_scan  = 1'b0;
    w_last  = 1'b0;
    w_drop  = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (w_win_ready) begin
          w_take  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        w_scan = 1'b1;
        if (scan_k_q == c_last_lane) begin
          w_last  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (peak_ack) begin
          w_drop  = 1'b1;
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  // Collection mask and timeout counter; a pulse in the snapshot cycle opens the new window
  always_comb begin
    coll_mask_d = coll_mask_q | corr_rdy;
    cnt_d       = cnt_q;
    if (w_take) begin
      coll_mask_d = corr_rdy;
      cnt_d       = '0;
    end else if (coll_mask_q == '0) begin
      cnt_d = '0;
    end else if ((coll_mask_q != c_mask_full) && (cnt_q != c_timeout)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Collection registers: latest pulse per lane wins, independent of FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_mask_q <= '0;
      cnt_q       <= '0;
      for (int k = 0; k < NCH; k++) begin
        coll_val_q[k] <= '0;
      end
    end else begin
      coll_mask_q <= coll_mask_d;
      cnt_q       <= cnt_d;
      for (int k = 0; k < NCH; k++) begin
        if (corr_rdy[k]) begin
          coll_val_q[k] <= corr_val[k*W +: W];
        end
      end
    end
  end

  // Snapshot the closed window (values before this cycle's pulses)
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_mask_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        snap_val_q[k] <= '0;
      end
    end else if (w_take) begin
      snap_mask_q <= coll_mask_q;
      for (int k = 0; k < NCH; k++) begin
        snap_val_q[k] <= coll_val_q[k];
      end
    end
  end

  assign w_lane_val = snap_val_q[scan_k_q];
  assign w_lane_en  = snap_mask_q[scan_k_q];

  // Scan step: strict '>' keeps the lowest index on ties; runner-up counts ties
  always_comb begin
    best_valid_d = best_valid_q;
    best_idx_d   = best_idx_q;
    best_val_d   = best_val_q;
`ifdef PEAK_MARGIN_EN
    sec_valid_d  = sec_valid_q;
    sec_val_d    = sec_val_q;
`endif
    if (w_lane_en) begin
      if (!best_valid_q || (w_lane_val > best_val_q)) begin
        best_valid_d = 1'b1;
        best_idx_d   = scan_k_q;
        best_val_d   = w_lane_val;
`ifdef PEAK_MARGIN_EN
        if (best_valid_q) begin
          sec_valid_d = 1'b1;
          sec_val_d   = best_val_q;
        end
`endif
      end
`ifdef PEAK_MARGIN_EN
      else if (!sec_valid_q || (w_lane_val > sec_val_q)) begin
        sec_valid_d = 1'b1;
        sec_val_d   = w_lane_val;
      end
`endif
    end
  end

`ifdef PEAK_MARGIN_EN
  assign w_val2   = sec_valid_d ? sec_val_d : '0;
  assign w_margin = sec_valid_d ? (best_val_d - sec_val_d) : '0;
`else
  // Runner-up tracking is not built in this configuration.
`endif

  // Scan pointer and running best; cleared when a new window is snapshotted
  always_ff @(posedge clk) begin
    if (rst || w_take) begin
      scan_k_q     <= '0;
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_val_q   <= '0;
`ifdef PEAK_MARGIN_EN
      sec_valid_q  <= 1'b0;
      sec_val_q    <= '0;
`endif
    end else if (w_scan) begin
      scan_k_q     <= w_last ? '0 : (scan_k_q + IW'(1));
      best_valid_q <= best_valid_d;
      best_idx_q   <= best_idx_d;
      best_val_q   <= best_val_d;
`ifdef PEAK_MARGIN_EN
      sec_valid_q  <= sec_valid_d;
      sec_val_q    <= sec_val_d;
`endif
    end
  end

  // Result registers: loaded with the final lane folded in, held until ack
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid_q   <= 1'b0;
      peak_idx_q     <= '0;
      peak_val_q     <= '0;
      peak_partial_q <= 1'b0;
      peak_mask_q    <= '0;
`ifdef PEAK_MARGIN_EN
      peak_val2_q    <= '0;
      peak_margin_q  <= '0;
`endif
    end else if (w_last) begin
      peak_valid_q   <= 1'b1;
      peak_idx_q     <= best_idx_d;
      peak_val_q     <= best_val_d;
      peak_partial_q <= (snap_mask_q != c_mask_full);
      peak_mask_q    <= snap_mask_q;
`ifdef PEAK_MARGIN_EN
      peak_val2_q    <= w_val2;
      peak_margin_q  <= w_margin;
`endif
    end else if (w_drop) begin
      peak_valid_q <= 1'b0;
    end
  end

  assign peak_valid   = peak_valid_q;
  assign peak_idx     = peak_idx_q;
  assign peak_val     = peak_val_q;
  assign peak_partial = peak_partial_q;
  assign peak_mask    = peak_mask_q;
`ifdef PEAK_MARGIN_EN
  assign peak_val2    = peak_val2_q;
  assign peak_margin  = peak_margin_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_corr_peak_picker.sv
`default_nettype none
// ============================================================================
// Module   : tb_corr_peak_picker
// Function : Self-checking bench for corr_peak_picker. A window-level model
//            predicts every result; directed scenarios pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_corr_peak_picker;

  localparam int NCH     = 8;
  localparam int W       = 16;
  localparam int TIMEOUT = 64;

  logic             clk;
  logic             rst;
  logic [NCH*W-1:0] corr_val;
  logic [NCH-1:0]   corr_rdy;
  logic             peak_valid;
  logic             peak_ack;
  logic [2:0]       peak_idx;
  logic [W-1:0]     peak_val;
  logic             peak_partial;
  logic [NCH-1:0]   peak_mask;
`ifdef PEAK_MARGIN_EN
  logic [W-1:0]     peak_val2;
  logic [W-1:0]     peak_margin;
`endif

  corr_peak_picker #(.NCH(NCH), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .corr_val     (corr_val),
    .corr_rdy     (corr_rdy),
    .peak_valid   (peak_valid),
    .peak_ack     (peak_ack),
    .peak_idx     (peak_idx),
    .peak_val     (peak_val),
    .peak_partial (peak_partial),
    .peak_mask    (peak_mask)
`ifdef PEAK_MARGIN_EN
    ,
    .peak_val2    (peak_val2),
    .peak_margin  (peak_margin)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (window level) ----------------
  int             m_vals [NCH];
  logic [NCH-1:0] m_mask;
  int             m_cnt;
  int             m_phase;   // 0 collecting, 1 scanning, 2 result held
  int             m_left;
  int             s_vals [NCH];
  logic [NCH-1:0] s_mask;
  logic           e_valid;
  int             e_idx, e_val, e_val2, e_margin;
  logic           e_partial;
  logic [NCH-1:0] e_mask;

  function automatic void publish();
    int bi, bv, sv, nrest;
    bi = -1; bv = 0; sv = 0; nrest = 0;
    for (int k = 0; k < NCH; k++)
      if (s_mask[k] && (bi < 0 || s_vals[k] > bv)) begin bi = k; bv = s_vals[k]; end
    for (int k = 0; k < NCH; k++)
      if (s_mask[k] && k != bi) begin
        if (nrest == 0 || s_vals[k] > sv) sv = s_vals[k];
        nrest++;
      end
    e_valid   = 1'b1;
    e_idx     = bi;
    e_val     = bv;
    e_val2    = (nrest > 0) ? sv : 0;
    e_margin  = (nrest > 0) ? (bv - sv) : 0;
    e_partial = (s_mask != '1);
    e_mask    = s_mask;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin m_vals[k] = 0; s_vals[k] = 0; end
      m_mask = '0; m_cnt = 0; m_phase = 0; m_left = 0; s_mask = '0;
      e_valid = 1'b0; e_idx = 0; e_val = 0; e_val2 = 0; e_margin = 0;
      e_partial = 1'b0; e_mask = '0;
    end else begin
      bit took;
      took = 1'b0;
      case (m_phase)
        0: if (m_mask == '1 || m_cnt == TIMEOUT) begin
             s_vals = m_vals; s_mask = m_mask;
             m_mask = '0; m_cnt = 0; m_phase = 1; m_left = NCH; took = 1'b1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin publish(); m_phase = 2; end
           end
        default: if (peak_ack) begin e_valid = 1'b0; m_phase = 0; end
      endcase
      if (!took) begin
        if (m_mask == '0) m_cnt = 0;
        else if (m_mask != '1 && m_cnt < TIMEOUT) m_cnt++;
      end
      for (int k = 0; k < NCH; k++)
        if (corr_rdy[k]) begin m_vals[k] = int'(corr_val[k*W +: W]); m_mask[k] = 1'b1; end
    end
  end

  // Compare process: outputs checked every cycle away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_valid", peak_valid, e_valid);
      if (e_valid) begin
        check("m_idx", peak_idx, e_idx);
        check("m_val", peak_val, e_val);
        check("m_partial", peak_partial, e_partial);
        check("m_mask", peak_mask, e_mask);
`ifdef PEAK_MARGIN_EN
        check("m_val2", peak_val2, e_val2);
        check("m_margin", peak_margin, e_margin);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] m, input logic [NCH*W-1:0] v);
    corr_rdy = m;
    corr_val = v;
    tick();
    corr_rdy = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!peak_valid && n < 400) begin
      tick();
      n++;
    end
    if (!peak_valid) check("wait_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic ack();
    peak_ack = 1'b1;
    tick();
    peak_ack = 1'b0;
    check("valid_drop_after_ack", peak_valid, 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, peak_valid, 64'd0);
    check({tag, "_idx"}, peak_idx, 64'd0);
    check({tag, "_val"}, peak_val, 64'd0);
    check({tag, "_partial"}, peak_partial, 64'd0);
    check({tag, "_mask"}, peak_mask, 64'd0);
  endtask

  function automatic logic [NCH*W-1:0] mk(input int v0, v1, v2, v3, v4, v5, v6, v7);
    logic [NCH*W-1:0] r;
    int a [NCH];
    a = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int k = 0; k < NCH; k++) r[k*W +: W] = W'(a[k]);
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n, n2;
    logic [NCH*W-1:0] v;
    rst = 1'b1; corr_rdy = '0; corr_val = '0; peak_ack = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("reset");

    // 1: one lane per cycle, result 9 cycles after the last pulse, stable while unacked
    v = mk(10, 20, 90, 30, 40, 50, 60, 70);
    for (int k = 0; k < NCH; k++) drive(NCH'(1) << k, v);
    wait_valid(n);
    check("t1_latency", n, 64'd9);
    check("t1_idx", peak_idx, 64'd2);
    check("t1_val", peak_val, 64'd90);
    check("t1_partial", peak_partial, 64'd0);
    check("t1_mask", peak_mask, 64'hFF);
    repeat (5) tick();
    check("t1_hold_valid", peak_valid, 64'd1);
    check("t1_hold_val", peak_val, 64'd90);
    ack();

    // 2: tie resolves to lowest lane
    drive('1, mk(100, 100, 100, 500, 100, 100, 500, 100));
    wait_valid(n);
    check("t2_idx", peak_idx, 64'd3);
    check("t2_val", peak_val, 64'd500);
`ifdef PEAK_MARGIN_EN
    check("t2_val2", peak_val2, 64'd500);
    check("t2_margin", peak_margin, 64'd0);
`endif
    ack();

    // 3: partial window closed by timeout
    drive(8'h02, mk(0, 7, 0, 0, 0, 0, 0, 0));
    repeat (20) tick();
    drive(8'h20, mk(0, 0, 0, 0, 0, 9, 0, 0));
    wait_valid(n2);
    check("t3_latency", 21 + n2, 64'd73);
    check("t3_idx", peak_idx, 64'd5);
    check("t3_val", peak_val, 64'd9);
    check("t3_partial", peak_partial, 64'd1);
    check("t3_mask", peak_mask, 64'h22);
    ack();

    // 4: backpressure, second window waits and keeps updating
    drive('1, mk(11, 22, 33, 44, 400, 55, 66, 77));
    drive('1, mk(250, 12, 13, 14, 15, 16, 17, 18));
    wait_valid(n);
    check("t4a_idx", peak_idx, 64'd4);
    check("t4a_val", peak_val, 64'd400);
    repeat (3) tick();
    drive(8'h01, mk(300, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tick();
    ack();
    wait_valid(n);
    check("t4b_idx", peak_idx, 64'd0);
    check("t4b_val", peak_val, 64'd300);
    check("t4b_mask", peak_mask, 64'hFF);
    ack();

    // 5: pulses in the snapshot cycle belong to the next window
    drive('1, mk(1, 2, 3, 4, 5, 6, 60, 7));
    drive('1, mk(5, 800, 5, 5, 5, 5, 5, 5));
    wait_valid(n);
    check("t5a_idx", peak_idx, 64'd6);
    check("t5a_val", peak_val, 64'd60);
    ack();
    wait_valid(n);
    check("t5b_idx", peak_idx, 64'd1);
    check("t5b_val", peak_val, 64'd800);
    check("t5b_mask", peak_mask, 64'hFF);
    ack();

    // 6: reset mid-scan and mid-hold, then a fresh window
    drive('1, mk(9, 9, 9, 9, 9, 9, 9, 99));
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_zero("t6_scan_rst");
    drive('1, mk(9, 9, 9, 9, 9, 99, 9, 9));
    wait_valid(n);
    rst = 1'b1; tick(); rst = 1'b0;
    check_zero("t6_hold_rst");
    drive('1, mk(3, 1, 4, 1, 5, 9, 2, 6));
    wait_valid(n);
    check("t6_fresh_idx", peak_idx, 64'd5);
    check("t6_fresh_val", peak_val, 64'd9);
    ack();

    // Random traffic: sparse pulses, frequent ties, random acks, rare resets
    for (int c = 0; c < 4000; c++) begin
      logic [NCH-1:0] m;
      for (int k = 0; k < NCH; k++) begin
        m[k] = ($urandom_range(0, 5) == 0);
        v[k*W +: W] = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      end
      corr_rdy = m;
      corr_val = v;
      peak_ack = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 799) == 0);
      tick();
    end
    corr_rdy = '0; peak_ack = 1'b0; rst = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
